platform_collision: RTL
=======================

Name: platform_collision

Overview:
- Downstream consumer of the platform field (platform positions plus activation mask) and a peer of the platform renderer.
- Once per frame, on `frame_start`, it scans all platform slots sequentially, one per clock.
- It decides whether the falling doodle's feet touch the top band of an active platform.
- It reports hit / index / landing y to the physics (jump) block before the next frame.

Parameters:
- N_PLAT, 93, number of platform slots scanned (index 0..N_PLAT-1)
- PLAT_W, 100, platform width in pixels
- DOODLE_W, 80, doodle sprite width in pixels
- DOODLE_H, 80, doodle sprite height in pixels
- FOOT_MARGIN, 20, horizontal inset of the foot zone from each sprite edge
- LAND_TOL, 16, depth in pixels of the landing band below the platform top

Ports:
- clk, in, 1, clock
- rst, in, 1, synchronous active-high reset
- frame_start, in, 1, one-cycle pulse per frame (vblank start); starts a scan
- doodle_x, in, 11 signed, sprite left edge x
- doodle_y, in, 11 signed, sprite top edge y
- doodle_falling, in, 1, 1 when vertical velocity is downward (screen y increasing)
- platforms, in, [N_PLAT-1:0][1:0][10:0] signed, per slot: [0] = top y, [1] = left x
- platform_activation, in, N_PLAT, per-slot enable
- busy, out, 1, high while a scan is in progress
- done, out, 1, one-cycle pulse when the result is valid
- hit, out, 1, a landing was found in the last completed scan
- hit_index, out, 7, slot index of the winning platform (0 if no hit)
- hit_y, out, 11 signed, doodle_y value that rests the feet on the platform top (platform y - DOODLE_H); 0 if no hit

Behaviour:
- Reset: state IDLE; busy=0, done=0, hit=0, hit_index=0, hit_y=0; scan counter=0; latched doodle registers=0.
- FSM: IDLE -> SCAN -> REPORT -> IDLE.
  - IDLE: on frame_start, latch doodle_x, doodle_y and doodle_falling; clear the internal candidate; counter=0; go to SCAN; busy=1 from the next cycle.
  - SCAN: evaluate slot[counter] each cycle.
    - At counter == N_PLAT-1, go to REPORT.
    - Otherwise increment counter.
    - No early exit: scan length is fixed.
  - REPORT: for one cycle, copy the candidate to hit / hit_index / hit_y; pulse done=1; busy=0; return to IDLE.
- Latency: frame_start sampled in cycle 0; slots evaluated in cycles 1..N_PLAT; done high in cycle N_PLAT+1 (cycle 94 with defaults).
- hit, hit_index and hit_y hold their values until the next REPORT or reset.
- Hit test for slot k. All arithmetic is 12-bit signed with inputs sign-extended, so no wrap at the screen edges. The test passes only if all of the following hold:
  - platform_activation[k] = 1
  - the latched doodle_falling = 1
  - foot zone overlaps the platform in x: fx0 = dx + FOOT_MARGIN; fx1 = dx + DOODLE_W - FOOT_MARGIN - 1; px0 = platforms[k][1]; px1 = px0 + PLAT_W - 1; overlap iff fx0 <= px1 and fx1 >= px0 (inclusive)
  - feet bottom fb = dy + DOODLE_H lies within py <= fb <= py + LAND_TOL - 1, where py = platforms[k][0]
- Priority: the first passing slot (lowest index) wins; later passes in the same scan are ignored.
- Landing value: hit_y = py - DOODLE_H, truncated to 11 bits.
- Platform inputs are read live during SCAN. Upstream must hold them stable from frame_start to done.
- Doodle inputs are used only as latched at frame_start.
- frame_start while busy (SCAN or REPORT) is ignored; no restart, no queueing.
- frame_start in the same cycle as REPORT is also ignored.
- rst mid-scan aborts: state IDLE next cycle, all outputs cleared, no done pulse.
- Negative coordinates (platforms above or left of the screen, e.g. y = -162) are legal and are compared signed.

Test Plan:
- Single landing: only slot 40 active at y=228, x=456; doodle x=460, y=148, falling=1; frame_start pulse -> done in cycle 94, busy high cycles 1..93, hit=1, hit_index=40, hit_y=148.
- Not falling: same setup with doodle_falling=0 at frame_start (set to 1 afterwards) -> done in cycle 94, hit=0, hit_index=0, hit_y=0.
- Band edges:
  - doodle_y=163 (fb=243=228+15) -> hit=1.
  - doodle_y=164 (fb=244) -> hit=0.
  - doodle_y=147 (fb=227) -> hit=0.
- X edges, slot 40 (px 456..555):
  - doodle_x=536 (fx0=556) -> hit=0.
  - doodle_x=535 (fx0=555) -> hit=1.
  - doodle_x=397 (fx1=456) -> hit=1.
  - doodle_x=396 (fx1=455) -> hit=0.
- Priority / negative coordinates:
  - Slots 5 and 40 both satisfy the test -> hit_index=5.
  - Slot 0 at y=-162, doodle_y=-242, x overlapping -> hit=1, hit_y=-242.
- Control:
  - Second frame_start at cycle 50 -> ignored; single done at cycle 94.
  - rst at cycle 30 -> busy=0 and hit=0 at cycle 31; no done pulse.
  - New frame_start afterwards -> normal 94-cycle scan.

Source files
------------

// File: rtl/platform_collision_if.sv
// platform_collision_if
// Bundles the frame-scan request, the platform field and the landing result
// exchanged between the game logic (master) and the collision scanner
// (slave).
//
// Signals:
//   frame_start          master->slave  one-cycle scan request
//   doodle_x/doodle_y    master->slave  sprite top-left corner (signed)
//   doodle_falling       master->slave  vertical velocity is downward
//   platforms            master->slave  per slot: [0]=top y, [1]=left x
//   platform_activation  master->slave  per-slot enable
//   busy                 slave->master  scan in progress
//   done                 slave->master  one-cycle result-valid pulse
//   hit/hit_index/hit_y  slave->master  landing result, held until next done
//   state_dbg            slave->master  scanner FSM state for observation
//
// Handshake: frame_start is a one-cycle request. It is accepted only while
// the scanner is idle (busy=0 and done=0); at any other time it is dropped,
// not queued. Every accepted request produces exactly one done pulse, unless
// rst intervenes. The result outputs are valid in the done cycle and stay
// stable until the next done pulse or reset. The master holds platforms and
// platform_activation stable from the accepted frame_start until done.
interface platform_collision_if #(
    parameter int N_PLAT = 93
);
    logic                                frame_start;
    logic signed [10:0]                  doodle_x;
    logic signed [10:0]                  doodle_y;
    logic                                doodle_falling;
    logic signed [N_PLAT-1:0][1:0][10:0] platforms;
    logic [N_PLAT-1:0]                   platform_activation;
    logic                                busy;
    logic                                done;
    logic                                hit;
    logic [6:0]                          hit_index;
    logic signed [10:0]                  hit_y;
    logic [1:0]                          state_dbg;

    modport master (
        output frame_start, doodle_x, doodle_y, doodle_falling,
               platforms, platform_activation,
        input  busy, done, hit, hit_index, hit_y, state_dbg
    );

    modport slave (
        input  frame_start, doodle_x, doodle_y, doodle_falling,
               platforms, platform_activation,
        output busy, done, hit, hit_index, hit_y, state_dbg
    );
endinterface

// File: rtl/platform_collision.sv
// platform_collision
// Once per frame, scans every platform slot (one per clock) and decides
// whether the falling doodle's feet land in the top band of an active
// platform. The lowest-index landing wins and is reported to the jump logic.
//
// Ports:
//   clk  clock
//   rst  synchronous active-high reset; aborts a scan without a done pulse
//   bus  platform_collision_if.slave (request, platform field, result)
//
// Timing: frame_start sampled in cycle 0, slots 0..N_PLAT-1 evaluated in
// cycles 1..N_PLAT, done in cycle N_PLAT+1.
module platform_collision #(
    parameter int N_PLAT      = 93,
    parameter int PLAT_W      = 100,
    parameter int DOODLE_W    = 80,
    parameter int DOODLE_H    = 80,
    parameter int FOOT_MARGIN = 20,
    parameter int LAND_TOL    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    platform_collision_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    // 12-bit signed geometry constants so sums never wrap at screen edges.
    localparam logic signed [11:0] FOOT_L  = 12'(FOOT_MARGIN);
    localparam logic signed [11:0] FOOT_R  = 12'(DOODLE_W - FOOT_MARGIN - 1);
    localparam logic signed [11:0] PLAT_R  = 12'(PLAT_W - 1);
    localparam logic signed [11:0] SPR_H   = 12'(DOODLE_H);
    localparam logic signed [11:0] BAND_LO = 12'(LAND_TOL - 1);
    localparam logic [6:0]         LAST    = 7'(N_PLAT - 1);

    state_t state;
    state_t state_nxt;

    logic [6:0]         cnt;
    logic signed [10:0] dx_q;
    logic signed [10:0] dy_q;
    logic               fall_q;

    // Candidate collected during the scan, and the result held between scans.
    logic               cand_hit;
    logic [6:0]         cand_idx;
    logic signed [10:0] cand_y;
    logic               hit_q;
    logic [6:0]         idx_q;
    logic signed [10:0] y_q;

    logic               last;
    logic signed [11:0] fx0, fx1, px0, px1, fb, py, land_y;
    logic               x_overlap, in_band, slot_pass;

    assign last = (cnt == LAST);

    // Hit test for the slot under the counter; platform field is read live.
    always_comb begin
        fx0       = {dx_q[10], dx_q} + FOOT_L;
        fx1       = {dx_q[10], dx_q} + FOOT_R;
        fb        = {dy_q[10], dy_q} + SPR_H;
        px0       = {bus.platforms[cnt][1][10], bus.platforms[cnt][1]};
        py        = {bus.platforms[cnt][0][10], bus.platforms[cnt][0]};
        px1       = px0 + PLAT_R;
        land_y    = py - SPR_H;
        x_overlap = (fx0 <= px1) && (fx1 >= px0);
        in_band   = (fb >= py) && (fb <= py + BAND_LO);
        slot_pass = bus.platform_activation[cnt] && fall_q && x_overlap && in_band;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic. frame_start outside IDLE is simply not looked at.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.frame_start) state_nxt = SCAN;
            SCAN:    if (last)            state_nxt = REPORT;
            REPORT:                       state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Outputs. In REPORT the fresh candidate is shown directly so the result
    // is valid in the same cycle as done; afterwards the held copy is shown.
    always_comb begin
        bus.busy      = (state == SCAN);
        bus.done      = (state == REPORT);
        bus.state_dbg = state;
        if (state == REPORT) begin
            bus.hit       = cand_hit;
            bus.hit_index = cand_idx;
            bus.hit_y     = cand_y;
        end else begin
            bus.hit       = hit_q;
            bus.hit_index = idx_q;
            bus.hit_y     = y_q;
        end
    end

    // Scan datapath: doodle latch, slot counter, candidate and held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            fall_q   <= 1'b0;
            cand_hit <= 1'b0;
            cand_idx <= '0;
            cand_y   <= '0;
            hit_q    <= 1'b0;
            idx_q    <= '0;
            y_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.frame_start) begin
                        dx_q     <= bus.doodle_x;
                        dy_q     <= bus.doodle_y;
                        fall_q   <= bus.doodle_falling;
                        cnt      <= '0;
                        cand_hit <= 1'b0;
                        cand_idx <= '0;
                        cand_y   <= '0;
                    end
                end
                SCAN: begin
                    if (!last) cnt <= cnt + 7'd1;
                    // First passing slot wins; later passes are ignored.
                    if (slot_pass && !cand_hit) begin
                        cand_hit <= 1'b1;
                        cand_idx <= cnt;
                        cand_y   <= land_y[10:0];
                    end
                end
                REPORT: begin
                    hit_q <= cand_hit;
                    idx_q <= cand_idx;
                    y_q   <= cand_y;
                end
                default: ;
            endcase
        end
    end

endmodule
